// File: rtl/lookahead_adder_pipe_if.sv
// rtl/lookahead_adder_pipe_if.sv - operand/result handshake bundle for lookahead_adder_pipe
interface lookahead_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Pin;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Pout;
    logic             Z;
    logic             V;

    // Producer/consumer side: drives operands and accepts results
    modport master (
        output in_valid, A, B, Pin, SUB, out_ready,
        input  in_ready, out_valid, S, Pout, Z, V
    );

    // Adder side
    modport slave (
        input  in_valid, A, B, Pin, SUB, out_ready,
        output in_ready, out_valid, S, Pout, Z, V
    );
endinterface

// File: rtl/lookahead_adder_pipe.sv
// rtl/lookahead_adder_pipe.sv - two-stage two-level carry-lookahead add/sub; flags via LOOKAHEAD_ADDER_PIPE_FLAGS_EN
module lookahead_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lookahead_adder_pipe_if.slave bus
);
    localparam int NG = WIDTH / 4;

    // Both stages move together; a stalled output freezes the whole pipe.
    logic advance;
    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    // Stage 1 combinational: operand conditioning and per-group generate/propagate
    logic [WIDTH-1:0]  b_eff;
    logic              c0_in;
    logic [WIDTH-1:0]  d_full;
    logic [WIDTH-1:0]  f_in;
    logic [3*NG-1:0]   d_lo_in;
    logic [NG-1:0]     gd_in;
    logic [NG-1:0]     gf_in;

    assign b_eff  = bus.SUB ? ~bus.B : bus.B;
    assign c0_in  = bus.SUB ? 1'b1 : bus.Pin;
    assign d_full = bus.A & b_eff;
    assign f_in   = bus.A ^ b_eff;

    // Group lookahead cells; bit-3 generate of each group only feeds GD, so it is not kept
    always_comb begin
        d_lo_in = '0;
        gd_in   = '0;
        gf_in   = '0;
        for (int g = 0; g < NG; g++) begin
            d_lo_in[3*g +: 3] = d_full[4*g +: 3];
            gd_in[g] = d_full[4*g+3]
                     | (d_full[4*g+2] & f_in[4*g+3])
                     | (d_full[4*g+1] & f_in[4*g+2] & f_in[4*g+3])
                     | (d_full[4*g]   & f_in[4*g+1] & f_in[4*g+2] & f_in[4*g+3]);
            gf_in[g] = &f_in[4*g +: 4];
        end
    end

    // Stage 1 registers
    logic              v1;
    logic [3*NG-1:0]   d1;
    logic [WIDTH-1:0]  f1;
    logic [NG-1:0]     gd1;
    logic [NG-1:0]     gf1;
    logic              c0_1;

    // Stage 1 capture: valid follows in_valid on advance, operands load only with a beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            d1   <= '0;
            f1   <= '0;
            gd1  <= '0;
            gf1  <= '0;
            c0_1 <= 1'b0;
        end else if (advance) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                d1   <= d_lo_in;
                f1   <= f_in;
                gd1  <= gd_in;
                gf1  <= gf_in;
                c0_1 <= c0_in;
            end
        end
    end

    // Second-level lookahead: each group carry-in as a flat sum of products over GD/GF/C0
    logic [NG:0] cg;
    logic        acc;
    logic        term;
    always_comb begin
        cg    = '0;
        acc   = 1'b0;
        term  = 1'b0;
        cg[0] = c0_1;
        for (int g = 0; g < NG; g++) begin
            acc = c0_1;
            for (int j = 0; j <= g; j++) acc = acc & gf1[j];
            for (int j = 0; j <= g; j++) begin
                term = gd1[j];
                for (int k = j + 1; k <= g; k++) term = term & gf1[k];
                acc = acc | term;
            end
            cg[g+1] = acc;
        end
    end

    // In-group 4-bit lookahead carries seeded by the group carry-in, then the sum
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] s_next;
    always_comb begin
        carry = '0;
        for (int g = 0; g < NG; g++) begin
            carry[4*g]   = cg[g];
            carry[4*g+1] = d1[3*g] | (f1[4*g] & cg[g]);
            carry[4*g+2] = d1[3*g+1] | (f1[4*g+1] & d1[3*g])
                         | (f1[4*g+1] & f1[4*g] & cg[g]);
            carry[4*g+3] = d1[3*g+2] | (f1[4*g+2] & d1[3*g+1])
                         | (f1[4*g+2] & f1[4*g+1] & d1[3*g])
                         | (f1[4*g+2] & f1[4*g+1] & f1[4*g] & cg[g]);
        end
        s_next = f1 ^ carry;
    end

    // Stage 2 registers: result beat presented to the consumer
    logic             v2;
    logic [WIDTH-1:0] s2;
    logic             pout2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            s2    <= '0;
            pout2 <= 1'b0;
        end else if (advance) begin
            v2 <= v1;
            if (v1) begin
                s2    <= s_next;
                pout2 <= cg[NG];
            end
        end
    end

    assign bus.out_valid = v2;
    assign bus.S         = s2;
    assign bus.Pout      = pout2;

`ifdef LOOKAHEAD_ADDER_PIPE_FLAGS_EN
    logic a_msb1;
    logic b_msb1;
    logic z2;
    logic v_ovf2;

    // Operand sign bits carried alongside stage 1 for the overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb1 <= 1'b0;
            b_msb1 <= 1'b0;
        end else if (advance && bus.in_valid) begin
            a_msb1 <= bus.A[WIDTH-1];
            b_msb1 <= b_eff[WIDTH-1];
        end
    end

    // Zero and signed-overflow flags registered with S
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z2     <= 1'b0;
            v_ovf2 <= 1'b0;
        end else if (advance && v1) begin
            z2     <= (s_next == '0);
            v_ovf2 <= (a_msb1 == b_msb1) && (s_next[WIDTH-1] != a_msb1);
        end
    end

    assign bus.Z = z2;
    assign bus.V = v_ovf2;
`else
    assign bus.Z = 1'b0;
    assign bus.V = 1'b0;
`endif
endmodule

// File: tb/tb_lookahead_adder_pipe.sv
// tb/tb_lookahead_adder_pipe.sv - directed self-checking bench for lookahead_adder_pipe
module tb_lookahead_adder_pipe;
    localparam int WIDTH = 16;
`ifdef LOOKAHEAD_ADDER_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    lookahead_adder_pipe_if #(.WIDTH(WIDTH)) bus ();

    lookahead_adder_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic pin, input logic sub);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.Pin      = pin;
        bus.SUB      = sub;
    endtask

    // One isolated beat: accepted at the first edge, result visible after the second
    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic pin, input logic sub, input logic [15:0] es,
                          input logic ep, input logic ez, input logic ev);
        bus.out_ready = 1'b1;
        drive(1'b1, a, b, pin, sub);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check({tag, "_early_valid"}, bus.out_valid, 0);
        tick();
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_S"}, bus.S, es);
        check({tag, "_Pout"}, bus.Pout, ep);
        check({tag, "_Z"}, bus.Z, ez & FLAGS);
        check({tag, "_V"}, bus.V, ev & FLAGS);
        tick();
        check({tag, "_drained"}, bus.out_valid, 0);
    endtask

    initial begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_S", bus.S, 0);
        check("rst_Pout", bus.Pout, 0);
        check("rst_Z", bus.Z, 0);
        check("rst_V", bus.V, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        tick();

        single("carry_all",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        single("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        single("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        single("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
        single("sub_eq_pin", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        single("ovf_sub",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        single("grp_carry",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        // Back-to-back beats k+k; result 2k appears one edge after its accept edge
        bus.out_ready = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            if (t <= 10) drive(1'b1, 16'(t), 16'(t), 1'b0, 1'b0);
            else         drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            tick();
            if (t >= 2 && t <= 11) begin
                check($sformatf("b2b_valid_%0d", t), bus.out_valid, 1);
                check($sformatf("b2b_S_%0d", t), bus.S, 32'(2 * (t - 1)));
            end else begin
                check($sformatf("b2b_idle_%0d", t), bus.out_valid, 0);
            end
        end

        // Backpressure with two beats in flight
        drive(1'b1, 16'h0100, 16'h0023, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0200, 16'h0045, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        check("bp_in_ready_drop", bus.in_ready, 0);
        for (int t = 0; t < 3; t++) begin
            tick();
            check($sformatf("bp_valid_%0d", t), bus.out_valid, 1);
            check($sformatf("bp_S_%0d", t), bus.S, 16'h0123);
            check($sformatf("bp_in_ready_%0d", t), bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", bus.in_ready, 1);
        tick();
        check("bp_second_valid", bus.out_valid, 1);
        check("bp_second_S", bus.S, 16'h0245);
        tick();
        check("bp_drained", bus.out_valid, 0);

        // Reset mid-flight while stalled: must clear asynchronously
        drive(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0033, 16'h0044, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        check("mid_pre_valid", bus.out_valid, 1);
        check("mid_pre_S", bus.S, 16'h0033);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_S", bus.S, 0);
        check("mid_rst_Pout", bus.Pout, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            check($sformatf("post_rst_idle_%0d", t), bus.out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
